ex_divider: RTL
===============

# ex_divider

Multi-cycle 32-bit integer divider in the EX stage; executes DIV/DIVU and writes {remainder, quotient} to HI/LO. It is the upstream source of the pipeline controller's `stallreq_for_ex`: `stallreq_o` is held while a division is in flight, so the controller freezes the pipeline until the result is ready. One radix-2 restoring iteration per cycle; operands are latched at start.

## Interface
Parameters:
- `DATA_W`, 32, operand width; only 32 is supported.
- `CNT_W`, 6, iteration counter width.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start_i`  in  1  EX holds a DIV/DIVU; level, held high by EX while stalled.
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU; sampled with operands.
- `opdata1_i`  in  32  dividend; sampled in FREE when `start_i`=1.
- `opdata2_i`  in  32  divisor; sampled with dividend.
- `annul_i`  in  1  abort the current division (exception/flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; valid while `ready_o`=1.
- `ready_o`  out  1  result valid; high for exactly one cycle.
- `stallreq_o`  out  1  to controller `stallreq_for_ex`; combinational.

## Operation
- States: FREE, BYZERO, ON, END. Reset forces FREE, counter 0, `result_o`=0, `ready_o`=0.
- FREE: if `start_i`=1 and `annul_i`=0, latch operands and `signed_div_i`.
  - Divisor 0 → BYZERO when `DIV_ZERO_FAST_EN` is defined, else → ON.
  - Divisor nonzero → ON.
  - In signed mode, ON works on absolute values: |x| = two's-complement negate if bit 31 is set.
- ON: one iteration per cycle, counter 0..31.
  - Shift the 64-bit partial remainder left by 1.
  - Compare the upper 33 bits against the divisor.
  - Subtract if ≥ and set quotient bit to 1, else 0.
  - After iteration 31 → END.
- BYZERO: result = {opdata1 as latched, 32'hFFFF_FFFF} → END.
- Divide-by-zero result is identical with or without the macro, independent of `signed_div_i`. In the ON path, divisor 0 is special-cased at the final fix-up.
- Signed fix-up at END entry:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0 (wraps, no trap).
- END: `ready_o`=1 and `result_o` is driven; next cycle is unconditionally FREE.
  - `result_o` holds its value in FREE until the next END.
- `annul_i`=1 in any state → FREE next cycle; `ready_o` stays 0 and `result_o` is unchanged. `annul_i` has priority over `start_i`.
- `stallreq_o` = `start_i` & ~`ready_o` & ~`annul_i`.

## Timing
- Start sampled in cycle 0 (FREE); ON occupies cycles 1–32; END (`ready_o`=1) in cycle 33. Latency is 33 cycles.
- `stallreq_o` is high in cycles 0–32 and low in cycle 33, so the pipeline advances on the edge ending cycle 33.
- Back-to-back divides: cycle 34 is FREE; if the next instruction's `start_i`=1, it starts there. It does not reuse the END cycle.
- BYZERO path (macro on): cycle 0 FREE, cycle 1 BYZERO, cycle 2 END. Latency is 2 cycles.
- `rst` mid-operation: FREE next cycle and outputs return to reset values; any `start_i` in the reset cycle is ignored.
- Operand changes after cycle 0 have no effect.

## Configuration
- `DIV_ZERO_FAST_EN` defined: a zero divisor takes the BYZERO path, with 2-cycle latency and stall.
- Undefined: the BYZERO state is not built; a zero divisor runs the full 33-cycle ON path and returns the same values.

## Test plan
- DIVU 100 / 7, `start_i` held → `stallreq_o` high for 33 cycles; cycle 33 `ready_o`=1, `result_o`=0x00000002_0000000E; cycle 34 FREE.
- DIV 0xFFFF_FFF9 (−7) / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. DIV 7 / 0xFFFF_FFFE (−2) → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `result_o`=0x00000000_80000000; no extra cycles.
- DIVU 0x1234_5678 / 0 → `result_o`=0x12345678_FFFFFFFF; `ready_o` at cycle 2 with the macro, cycle 33 without.
- `annul_i` pulsed at cycle 10 → FREE at cycle 11, `ready_o` never asserts, `stallreq_o`=0 from cycle 10; a new DIVU 9/3 then returns 0x00000000_00000003 after 33 cycles.
- `rst` asserted at cycle 20 → cycle 21 FREE, `ready_o`=0, `result_o`=0. Back-to-back DIVUs 10/3 then 20/6 → `ready_o` in cycles 33 and 67.

Source files
------------

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle 32-bit integer divider for the EX stage.
// Executes DIV/DIVU with one radix-2 restoring iteration per cycle and
// returns {remainder, quotient} for HI/LO. While a division is in flight
// stallreq_o holds the pipeline.
// Optional feature macro: DIV_ZERO_FAST_EN -- a zero divisor takes a short
// BYZERO path (2-cycle latency) instead of the full 33-cycle iteration.
module ex_divider #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_ON     = 2'b01,
        ST_END    = 2'b10
`ifdef DIV_ZERO_FAST_EN
        ,
        ST_BYZERO = 2'b11
`endif
    } state_t;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand; only negative when treated as signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            return neg32(v);
        end else begin
            return v;
        end
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [63:0]        work_r;        // {partial remainder, dividend/quotient}
    logic [31:0]        dividend_r;    // dividend as latched (sign, div-by-zero result)
    logic [31:0]        divisor_abs_r;
    logic               divisor_sign_r;
    logic               div_zero_r;
    logic               signed_r;
    logic [63:0]        result_r;
    logic               ready_r;

    logic               ge_s;
    logic [31:0]        diff_s;
    logic [63:0]        work_next_s;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [63:0]        final_s;

    // One restoring step: shift left, trial-subtract the divisor from the top 33 bits.
    always_comb begin
        ge_s   = (work_r[63:31] >= {1'b0, divisor_abs_r});
        diff_s = work_r[62:31] - divisor_abs_r;
        if (ge_s) begin
            work_next_s = {diff_s, work_r[30:0], 1'b1};
        end else begin
            work_next_s = {work_r[62:0], 1'b0};
        end
    end

    // Sign fix-up of the last step's result; a zero divisor bypasses it entirely.
    always_comb begin
        if (signed_r && (dividend_r[31] ^ divisor_sign_r)) begin
            quot_s = neg32(work_next_s[31:0]);
        end else begin
            quot_s = work_next_s[31:0];
        end
        if (signed_r && dividend_r[31]) begin
            rem_s = neg32(work_next_s[63:32]);
        end else begin
            rem_s = work_next_s[63:32];
        end
        if (div_zero_r) begin
            final_s = {dividend_r, 32'hFFFF_FFFF};
        end else begin
            final_s = {rem_s, quot_s};
        end
    end

    // Next-state logic; annul returns to FREE from any state.
    always_comb begin
        state_s = state_r;
        if (annul_i) begin
            state_s = ST_FREE;
        end else begin
            case (state_r)
                ST_FREE: begin
                    if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2_i == 32'd0) begin
                            state_s = ST_BYZERO;
                        end else begin
                            state_s = ST_ON;
                        end
`else
                        state_s = ST_ON;
`endif
                    end else begin
                        state_s = ST_FREE;
                    end
                end
                ST_ON: begin
                    if (cnt_r == CNT_W'(31)) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_ON;
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ST_BYZERO: state_s = ST_END;
`endif
                ST_END:  state_s = ST_FREE;
                default: state_s = ST_FREE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FREE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath and registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r          <= '0;
            work_r         <= 64'd0;
            dividend_r     <= 32'd0;
            divisor_abs_r  <= 32'd0;
            divisor_sign_r <= 1'b0;
            div_zero_r     <= 1'b0;
            signed_r       <= 1'b0;
            result_r       <= 64'd0;
            ready_r        <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                ST_FREE: begin
                    if (start_i && !annul_i) begin
                        cnt_r          <= '0;
                        work_r         <= {32'd0, abs32(opdata1_i, signed_div_i)};
                        dividend_r     <= opdata1_i;
                        divisor_abs_r  <= abs32(opdata2_i, signed_div_i);
                        divisor_sign_r <= opdata2_i[31];
                        div_zero_r     <= (opdata2_i == 32'd0);
                        signed_r       <= signed_div_i;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        cnt_r <= '0;
                    end else begin
                        work_r <= work_next_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(31)) begin
                            result_r <= final_s;
                            ready_r  <= 1'b1;
                        end
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ST_BYZERO: begin
                    if (!annul_i) begin
                        result_r <= {dividend_r, 32'hFFFF_FFFF};
                        ready_r  <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign result_o   = result_r;
    assign ready_o    = ready_r;
    assign stallreq_o = start_i & ~ready_r & ~annul_i;

endmodule
